spike_rate_meter: RTL and testbench
===================================

# spike_rate_meter

Downstream consumer of the spiking neuron's one-bit `spike` output. Counts spike rising edges over a programmable window of clock cycles and presents the count as a rate sample through a valid/ready output register. It optionally also measures the most recent inter-spike interval. It feeds the readout logic that drives the dedicated outputs and bidirectional IOs.

## Interface
Parameters:
- `CNT_W`, 8, width of the rate count; the count saturates at 2^CNT_W-1.
- `WIN_W`, 16, width of the window length and of the ISI counter.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  measurement enable.
- `spike`  in  1  neuron spike, synchronous to `clk`; no synchronizer required.
- `win_len`  in  WIN_W  window length in cycles; value 0 is treated as 1.
- `rate`  out  CNT_W  rising-edge count of the last completed window.
- `rate_sat`  out  1  count for the window in `rate` saturated.
- `rate_valid`  out  1  `rate` / `rate_sat` hold an unconsumed sample.
- `rate_ready`  in  1  consumer accepts the sample.
- `overrun`  out  1  sticky flag: a completed window was dropped because the output was full.
- `isi`  out  WIN_W  last inter-spike interval in cycles (see Configuration).

## Operation
- Edge detect: `rise = spike & ~spike_q`, where `spike_q` is registered `spike`.
  - A high level lasting several cycles counts once.
  - `spike_q` updates even while `en=0`.
- FSM states:
  - IDLE:
    - Window counter and spike counter are held at 0.
    - `en=1` latches `L = max(win_len,1)` and moves to COUNT on the next edge.
  - COUNT:
    - `wcnt` increments 0..L-1.
    - `scnt` increments on `rise`, saturating at 2^CNT_W-1; `sat` is set if an increment is attempted at max.
    - When `wcnt==L-1`, the window closes: the final count includes any `rise` in that cycle.
    - At close, `wcnt`/`scnt`/`sat` clear, `L` is re-latched from `win_len`, and counting continues back-to-back with no gap cycle.
  - `en=0` in any state → IDLE next cycle; the partial window is discarded.
    - A pending output sample is kept.
    - `overrun` is kept.
- Output register:
  - On window close with `rate_valid=0`, or with `rate_valid & rate_ready` in the same cycle: load `rate`/`rate_sat` and set `rate_valid=1`.
  - On window close with `rate_valid=1 & rate_ready=0`: keep the old sample, drop the new one, and set `overrun=1`.
  - Otherwise, `rate_valid & rate_ready` clears `rate_valid`.
  - `rate` and `rate_sat` are stable while `rate_valid=1` and not accepted.
- `overrun` clears only on reset.

## Timing
- Reset values:
  - `rate=0`, `rate_sat=0`, `rate_valid=0`, `overrun=0`, `isi=0`.
  - FSM is in IDLE, `spike_q=0`.
- Reset is asynchronous and may assert mid-window or mid-handshake. All state clears immediately; no sample is emitted.
- Latency:
  - `en` rising at edge k puts the FSM in COUNT from edge k+1.
  - Window cycles are the L cycles starting there.
  - `rate_valid` rises 1 cycle after the window's last cycle.
- Window period is exactly L cycles while `en=1`.
- A `win_len` change takes effect at the next window start only.
- `spike` high at edge n is counted in the window containing cycle n, provided `spike` was low at edge n-1.

## Configuration
- `SPIKE_RATE_ISI_EN` defined:
  - A WIDTH=WIN_W free-running counter `icnt` counts cycles since the last `rise`, saturating at 2^WIN_W-1.
  - On `rise`: if at least one earlier `rise` has been seen since reset, `isi <= icnt+1` (saturated); `icnt` then resets to 0.
  - The first `rise` only arms the measurement.
  - ISI measurement runs regardless of `en`.
- Not defined: `isi` is tied to 0 and the ISI counter is absent.

## Test plan
- Reset/basic:
  - Stimulus: `win_len=10`, `en=1`, `rate_ready=1`, single-cycle spikes at window cycles 0, 3, 9.
  - Required: `rate=3` and `rate_valid` pulses 1 cycle after window cycle 9, then `rate=0` for the next, empty window.
- Level vs edge:
  - Stimulus: `spike` held high for 5 cycles inside a window of 20.
  - Required: `rate=1`.
- Saturation:
  - Stimulus: `CNT_W=4`, `win_len=40`, spike toggling every cycle (20 edges).
  - Required: `rate=15`, `rate_sat=1`.
- Backpressure:
  - Stimulus: `win_len=4`, `rate_ready=0` for 3 windows.
  - Required: the first sample is held, `overrun=1` after the second close, and the sample is consumed when `rate_ready=1`.
  - Also: a close coinciding with acceptance loads the new sample with `rate_valid` staying 1.
- Abort:
  - Stimulus: `en` dropped mid-window, or `rst_n` pulsed mid-window.
  - Required: no sample is produced for that window.
  - On `en` drop: a pending sample survives.
  - On `rst_n` pulse: all outputs are 0 immediately.
- ISI (with `SPIKE_RATE_ISI_EN`):
  - Stimulus: rises at cycles 5 and 12, then 12 and 112.
  - Required: `isi=7`, then `isi=100`.
  - Without the macro: `isi` stays 0.

Source files
------------

// File: rtl/spike_rate_meter.sv
// spike_rate_meter: counts spike rising edges over a programmable window
// and presents each window's count through a valid/ready output register.
// Optional inter-spike-interval measurement when SPIKE_RATE_ISI_EN is defined.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           measurement enable (low aborts the current window)
//   spike        neuron spike level, synchronous to clk
//   win_len      window length in cycles (0 behaves as 1)
//   rate         edge count of the last completed window
//   rate_sat     that count saturated
//   rate_valid   rate/rate_sat hold an unconsumed sample
//   rate_ready   consumer accepts the sample
//   overrun      sticky: a completed window was dropped (output full)
//   isi          last inter-spike interval (0 when the ISI feature is off)
module spike_rate_meter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate,
    output logic             rate_sat,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic [WIN_W-1:0] isi
);

    localparam logic [WIN_W-1:0] WONE = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    state_e           state_q;
    logic             spike_q;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] wcnt_q;
    logic [CNT_W-1:0] scnt_q;
    logic             sat_q;
    logic [CNT_W-1:0] rate_q;
    logic             rate_sat_q;
    logic             rate_valid_q;
    logic             overrun_q;

    logic             rise;
    logic [WIN_W-1:0] len_d;
    logic             scnt_max;
    logic [CNT_W-1:0] scnt_d;
    logic             sat_d;
    logic             close;
    logic             load;

    assign rise     = spike & ~spike_q;
    assign len_d    = (win_len == '0) ? WONE : win_len;
    assign scnt_max = &scnt_q;

    // The closing cycle's own rise is folded into the sample.
    assign scnt_d = (rise && !scnt_max) ? scnt_q + CONE : scnt_q;
    assign sat_d  = sat_q | (rise & scnt_max);

    assign close = (state_q == S_COUNT) && en
                 && (wcnt_q == len_q - WONE);

    // A close may refill the register in the same cycle it is drained.
    assign load = close && (!rate_valid_q || rate_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            spike_q      <= 1'b0;
            len_q        <= WONE;
            wcnt_q       <= '0;
            scnt_q       <= '0;
            sat_q        <= 1'b0;
            rate_q       <= '0;
            rate_sat_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            spike_q <= spike;

            if (load) begin
                rate_q       <= scnt_d;
                rate_sat_q   <= sat_d;
                rate_valid_q <= 1'b1;
            end else if (rate_valid_q && rate_ready) begin
                rate_valid_q <= 1'b0;
            end

            if (close && rate_valid_q && !rate_ready) begin
                overrun_q <= 1'b1;
            end

            if (!en) begin
                state_q <= S_IDLE;
                wcnt_q  <= '0;
                scnt_q  <= '0;
                sat_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        len_q   <= len_d;
                        state_q <= S_COUNT;
                        wcnt_q  <= '0;
                        scnt_q  <= '0;
                        sat_q   <= 1'b0;
                    end
                    S_COUNT: begin
                        if (close) begin
                            len_q  <= len_d;
                            wcnt_q <= '0;
                            scnt_q <= '0;
                            sat_q  <= 1'b0;
                        end else begin
                            wcnt_q <= wcnt_q + WONE;
                            scnt_q <= scnt_d;
                            sat_q  <= sat_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rate       = rate_q;
    assign rate_sat   = rate_sat_q;
    assign rate_valid = rate_valid_q;
    assign overrun    = overrun_q;

`ifdef SPIKE_RATE_ISI_EN
    logic [WIN_W-1:0] icnt_q;
    logic [WIN_W-1:0] icnt_d;
    logic [WIN_W-1:0] isi_q;
    logic             armed_q;

    // Saturating "cycles since last rise, plus this one".
    assign icnt_d = (&icnt_q) ? icnt_q : icnt_q + WONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q  <= '0;
            isi_q   <= '0;
            armed_q <= 1'b0;
        end else if (rise) begin
            if (armed_q) begin
                isi_q <= icnt_d;
            end
            armed_q <= 1'b1;
            icnt_q  <= '0;
        end else begin
            icnt_q <= icnt_d;
        end
    end

    assign isi = isi_q;
`else
    assign isi = '0;
`endif

endmodule

// File: tb/tb_spike_rate_meter.sv
// tb_spike_rate_meter: table-driven windows plus hand-written corner cases,
// rate samples checked through an expected-value queue at each handshake.
module tb_spike_rate_meter;

`ifdef SPIKE_RATE_ISI_EN
    localparam int ISI_ON = 1;
`else
    localparam int ISI_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        spike = 1'b0;
    logic        rate_ready = 1'b0;
    logic [15:0] win_len = 16'd0;

    logic [7:0]  rate8;
    logic        sat8, val8, ovr8;
    logic [15:0] isi8;
    logic [3:0]  rate4;
    logic        sat4, val4, ovr4;
    logic [15:0] isi4;

    always #5 clk = ~clk;

    spike_rate_meter #(.CNT_W(8), .WIN_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .spike(spike),
        .win_len(win_len), .rate(rate8), .rate_sat(sat8),
        .rate_valid(val8), .rate_ready(rate_ready),
        .overrun(ovr8), .isi(isi8)
    );

    spike_rate_meter #(.CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .spike(spike),
        .win_len(win_len), .rate(rate4), .rate_sat(sat4),
        .rate_valid(val4), .rate_ready(rate_ready),
        .overrun(ovr4), .isi(isi4)
    );

    typedef struct {
        int r8;
        int s8;
        int r4;
        int s4;
    } exp_t;

    typedef struct {
        int          win;
        logic [63:0] m0;
        logic [63:0] m1;
        int          nwin;
    } vec_t;

    exp_t sb[$];
    vec_t vt[7];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(int n);
        exp_t e;
        e.r8 = (n > 255) ? 255 : n;
        e.s8 = (n > 255) ? 1 : 0;
        e.r4 = (n > 15) ? 15 : n;
        e.s4 = (n > 15) ? 1 : 0;
        return e;
    endfunction

    function automatic int edges(logic [63:0] m, int w, logic prev);
        int   n = 0;
        logic p = prev;
        for (int c = 0; c < w; c++) begin
            if (m[c] && !p) n++;
            p = m[c];
        end
        return n;
    endfunction

    // Accepted sample = valid & ready seen between edges.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && val8 && rate_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rate8", int'(rate8), e.r8);
                chk("sat8", int'(sat8), e.s8);
                chk("rate4", int'(rate4), e.r4);
                chk("sat4", int'(sat4), e.s4);
                chk("valid4", int'(val4), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [63:0] m, int w);
        for (int c = 0; c < w; c++) begin
            spike = m[c];
            tick();
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || val8) && t < 100) begin
            tick();
            t++;
        end
        chk("queue_drained", sb.size(), 0);
    endtask

    task automatic run_vec(vec_t v);
        int          w;
        logic        prev;
        logic [63:0] m;
        w = (v.win == 0) ? 1 : v.win;
        prev = 1'b0;
        rate_ready = 1'b1;
        win_len = v.win[15:0];
        en = 1'b1;
        tick();
        for (int k = 0; k < v.nwin; k++) begin
            m = (k == 0) ? v.m0 : v.m1;
            sb.push_back(mk(edges(m, w, prev)));
            for (int c = 0; c < w; c++) begin
                spike = m[c];
                // Mid-window length changes must not disturb the window.
                if (c > 0 && c < w - 1) win_len = v.win[15:0] + 16'd5;
                else win_len = v.win[15:0];
                tick();
            end
            prev = m[w-1];
        end
        en = 1'b0;
        spike = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{10, 64'h209, 64'h0, 2};
        vt[1] = '{20, 64'h1F0, 64'h0, 1};
        vt[2] = '{40, 64'h55_5555_5555, 64'h0, 1};
        vt[3] = '{0, 64'h1, 64'h1, 3};
        vt[4] = '{3, 64'h5, 64'h5, 3};
        vt[5] = '{16, 64'hFFFF, 64'hFFFF, 2};
        vt[6] = '{30, 64'h1555_5555, 64'h0, 1};

        #12;
        chk("rst_rate8", int'(rate8), 0);
        chk("rst_sat8", int'(sat8), 0);
        chk("rst_valid8", int'(val8), 0);
        chk("rst_ovr8", int'(ovr8), 0);
        chk("rst_isi8", int'(isi8), 0);
        chk("rst_rate4", int'(rate4), 0);
        chk("rst_valid4", int'(val4), 0);
        chk("rst_ovr4", int'(ovr4), 0);
        chk("rst_isi4", int'(isi4), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) run_vec(vt[i]);
        chk("no_overrun_yet", int'(ovr8), 0);

        // Latency and backpressure, window of 4, consumer stalled.
        rate_ready = 1'b0;
        win_len = 16'd4;
        en = 1'b1;
        tick();
        drive(64'h2, 3);
        chk("lat_not_yet", int'(val8), 0);
        spike = 1'b0;
        tick();
        chk("lat_valid", int'(val8), 1);
        chk("bp_first", int'(rate8), 1);
        chk("bp_ovr0", int'(ovr8), 0);
        drive(64'h5, 4);
        chk("bp_hold2", int'(rate8), 1);
        chk("bp_ovr1", int'(ovr8), 1);
        chk("bp_ovr4", int'(ovr4), 1);
        drive(64'h0, 4);
        chk("bp_hold3", int'(rate8), 1);
        chk("bp_valid3", int'(val8), 1);
        sb.push_back(mk(1));
        sb.push_back(mk(2));
        drive(64'h5, 3);
        rate_ready = 1'b1;
        spike = 1'b0;
        tick();
        chk("acc_close_valid", int'(val8), 1);
        chk("acc_close_rate", int'(rate8), 2);
        en = 1'b0;
        drain();

        // Enable dropped mid-window with a sample pending.
        rate_ready = 1'b0;
        en = 1'b1;
        tick();
        drive(64'h2, 4);
        chk("abort_pending", int'(val8), 1);
        drive(64'h1, 2);
        en = 1'b0;
        spike = 1'b0;
        repeat (3) tick();
        chk("abort_keep_valid", int'(val8), 1);
        chk("abort_keep_rate", int'(rate8), 1);
        chk("abort_keep_ovr", int'(ovr8), 1);
        sb.push_back(mk(1));
        rate_ready = 1'b1;
        tick();
        sb.push_back(mk(0));
        en = 1'b1;
        tick();
        drive(64'h0, 4);
        en = 1'b0;
        drain();

        // Reset mid-window while a sample is held.
        rate_ready = 1'b0;
        en = 1'b1;
        tick();
        drive(64'h2, 4);
        chk("rst_pending", int'(val8), 1);
        drive(64'h1, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_rate8", int'(rate8), 0);
        chk("arst_valid8", int'(val8), 0);
        chk("arst_ovr8", int'(ovr8), 0);
        chk("arst_valid4", int'(val4), 0);
        chk("arst_ovr4", int'(ovr4), 0);
        en = 1'b0;
        spike = 1'b0;
        tick();
        rst_n = 1'b1;
        rate_ready = 1'b1;
        repeat (6) tick();
        chk("arst_no_sample", int'(val8), 0);
        chk("arst_queue", sb.size(), 0);

        // Inter-spike interval, with enable low.
        spike = 1'b1;
        tick();
        spike = 1'b0;
        chk("isi_arm", int'(isi8), 0);
        repeat (6) tick();
        spike = 1'b1;
        tick();
        spike = 1'b0;
        chk("isi_7", int'(isi8), ISI_ON ? 7 : 0);
        repeat (99) tick();
        spike = 1'b1;
        tick();
        spike = 1'b0;
        chk("isi_100", int'(isi8), ISI_ON ? 100 : 0);
        chk("isi_100_w4", int'(isi4), ISI_ON ? 100 : 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
